// File: rtl/bnn_layer_engine_if.sv
`timescale 1ns/1ps
// bnn_layer_engine_if
// Bundles the control handshake and the three memory ports of the
// binary-neural-network layer engine.
//   control : start, in_len, out_len, last -> busy, done, err
//   weights : w_addr -> w_data (one-cycle read latency)
//   acts in : x_rd_addr -> x_rd_data (one-cycle read latency)
//   acts out: x_wr_en, x_wr_addr, x_wr_data
//   result  : class_out, class_valid
// master = the engine, slave = the surrounding system / memories.
interface bnn_layer_engine_if #(
  parameter int LANES      = 4,
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10
);
  logic                  start;
  logic [X_ADDR_LEN-1:0] in_len;
  logic [X_ADDR_LEN-1:0] out_len;
  logic                  last;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [W_ADDR_LEN-1:0] w_addr;
  logic [LANES-1:0]      w_data;
  logic [X_ADDR_LEN-1:0] x_rd_addr;
  logic [LANES-1:0]      x_rd_data;
  logic                  x_wr_en;
  logic [X_ADDR_LEN-1:0] x_wr_addr;
  logic                  x_wr_data;
  logic [X_ADDR_LEN-1:0] class_out;
  logic                  class_valid;

  modport master (
    input  start, in_len, out_len, last, w_data, x_rd_data,
    output busy, done, err, w_addr, x_rd_addr, x_wr_en, x_wr_addr, x_wr_data,
           class_out, class_valid
  );

  modport slave (
    output start, in_len, out_len, last, w_data, x_rd_data,
    input  busy, done, err, w_addr, x_rd_addr, x_wr_en, x_wr_addr, x_wr_data,
           class_out, class_valid
  );
endinterface

// File: rtl/bnn_layer_engine.sv
`timescale 1ns/1ps
// bnn_layer_engine
// Runs one fully-connected binary layer: for each neuron it XNOR-popcounts
// in_len/LANES weight words against the input activation words, then either
// writes the sign bit (2*acc >= in_len) to activation memory or, in
// classification mode (last=1), tracks the argmax neuron.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - bnn_layer_engine_if.master (control, memory ports, result)
// ACC_W must exceed X_ADDR_LEN so the accumulator can hold in_len.
module bnn_layer_engine #(
  parameter int LANES      = 4,
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int ACC_W      = 12
) (
  input logic                clk,
  input logic                rst,
  bnn_layer_engine_if.master bus
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, FIN} state_t;

  localparam logic [X_ADDR_LEN-1:0] ONE_X = 1;
  localparam logic [W_ADDR_LEN-1:0] ONE_W = 1;

  state_t                state_q, state_d;
  logic [X_ADDR_LEN-1:0] in_len_q, out_len_q, k_last_q, n_q, k_q;
  logic                  last_q, err_q, fetch_d_q;
  logic [W_ADDR_LEN-1:0] w_ctr_q;
  logic [ACC_W-1:0]      acc_q, best_acc_q, pop;
  logic [X_ADDR_LEN-1:0] best_idx_q, new_best_idx, wr_addr_q, class_out_q;
  logic                  wr_data_q, class_valid_q;
  logic [LANES-1:0]      match;
  logic [X_ADDR_LEN-1:0] chunks;
  logic                  cfg_bad, act, last_neuron, take_best;

  assign chunks  = bus.in_len / X_ADDR_LEN'(LANES);
  assign cfg_bad = (bus.in_len == '0) || (bus.out_len == '0) ||
                   ((bus.in_len % X_ADDR_LEN'(LANES)) != '0);

  // Ties resolve to 1 because the comparison is >=.
  assign act = {acc_q, 1'b0} >= {{(ACC_W + 1 - X_ADDR_LEN){1'b0}}, in_len_q};

  assign last_neuron  = (n_q == out_len_q - ONE_X);
  // Strictly greater keeps the lowest index on ties.
  assign take_best    = (n_q == '0) || (acc_q > best_acc_q);
  assign new_best_idx = take_best ? n_q : best_idx_q;

  always_comb begin
    match = ~(bus.w_data ^ bus.x_rd_data);
    pop   = '0;
    for (int i = 0; i < LANES; i++) pop = pop + ACC_W'(match[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = cfg_bad ? FIN : FETCH;
      FETCH:   if (k_q == k_last_q) state_d = DRAIN;
      DRAIN:   state_d = WRITE;
      WRITE:   state_d = last_neuron ? FIN : FETCH;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data arrives one cycle after its address, so accumulation is keyed
  // off a delayed FETCH flag; the final word is added during DRAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_len_q      <= '0;
      out_len_q     <= '0;
      last_q        <= 1'b0;
      err_q         <= 1'b0;
      k_last_q      <= '0;
      n_q           <= '0;
      k_q           <= '0;
      w_ctr_q       <= '0;
      acc_q         <= '0;
      fetch_d_q     <= 1'b0;
      best_acc_q    <= '0;
      best_idx_q    <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= 1'b0;
      class_out_q   <= '0;
      class_valid_q <= 1'b0;
    end else begin
      fetch_d_q <= (state_q == FETCH);
      if (fetch_d_q) acc_q <= acc_q + pop;
      case (state_q)
        IDLE: if (bus.start) begin
          in_len_q      <= bus.in_len;
          out_len_q     <= bus.out_len;
          last_q        <= bus.last;
          err_q         <= cfg_bad;
          k_last_q      <= chunks - ONE_X;
          n_q           <= '0;
          k_q           <= '0;
          w_ctr_q       <= '0;
          acc_q         <= '0;
          class_valid_q <= 1'b0;
        end
        FETCH: begin
          w_ctr_q <= w_ctr_q + ONE_W;
          if (k_q != k_last_q) k_q <= k_q + ONE_X;
        end
        WRITE: begin
          acc_q <= '0;
          k_q   <= '0;
          if (!last_q) begin
            wr_addr_q <= n_q;
            wr_data_q <= act;
          end else begin
            if (take_best) begin
              best_acc_q <= acc_q;
              best_idx_q <= n_q;
            end
            // Publish the result so it is already valid in the done cycle.
            if (last_neuron) begin
              class_out_q   <= new_best_idx;
              class_valid_q <= 1'b1;
            end
          end
          if (!last_neuron) n_q <= n_q + ONE_X;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == FIN);
  assign bus.err         = (state_q == FIN) && err_q;
  assign bus.w_addr      = w_ctr_q;
  assign bus.x_rd_addr   = k_q;
  assign bus.x_wr_en     = (state_q == WRITE) && !last_q;
  assign bus.x_wr_addr   = bus.x_wr_en ? n_q : wr_addr_q;
  assign bus.x_wr_data   = bus.x_wr_en ? act : wr_data_q;
  assign bus.class_out   = class_out_q;
  assign bus.class_valid = class_valid_q;

endmodule

// File: tb/tb_bnn_layer_engine.sv
`timescale 1ns/1ps
// tb_bnn_layer_engine
// Directed bench for bnn_layer_engine with LANES=4. Weight and activation
// memories are small arrays with one-cycle registered reads; writes are
// logged by a monitor. Cycle i of a run is sampled 1ns after the i-th
// rising edge following the cycle in which start was presented.
module tb_bnn_layer_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;

  bnn_layer_engine_if #(.LANES(4), .W_ADDR_LEN(20), .X_ADDR_LEN(10)) bus ();

  bnn_layer_engine #(.LANES(4), .W_ADDR_LEN(20), .X_ADDR_LEN(10), .ACC_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [3:0]  wmem [0:15];
  logic [3:0]  xmem [0:15];
  logic [9:0]  wr_addr_log [0:63];
  logic        wr_data_log [0:63];
  int          wr_cnt = 0;
  logic [19:0] waddr_trace [0:63];
  logic        err_at_done, cv_at_done;
  logic [9:0]  co_at_done;
  int          n_cmp = 0;
  int          n_fail = 0;

  always @(posedge clk) begin
    bus.w_data    <= wmem[bus.w_addr[3:0]];
    bus.x_rd_data <= xmem[bus.x_rd_addr[3:0]];
  end

  always @(posedge clk) begin
    if (bus.x_wr_en) begin
      wr_addr_log[wr_cnt & 63] = bus.x_wr_addr;
      wr_data_log[wr_cnt & 63] = bus.x_wr_data;
      wr_cnt = wr_cnt + 1;
    end
  end

  // Presents start for one cycle and waits (bounded) for done; the cycle
  // index of done is returned, -1 if it never came.
  task automatic run_layer(input logic [9:0] il, input logic [9:0] ol,
                           input logic lst, output int done_at);
    bus.start = 1'b1; bus.in_len = il; bus.out_len = ol; bus.last = lst;
    done_at = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      waddr_trace[i] = bus.w_addr;
      if (bus.done) begin
        done_at = i; err_at_done = bus.err;
        cv_at_done = bus.class_valid; co_at_done = bus.class_out;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic load_words(input logic [3:0] w0, w1, w2, w3, w4, w5);
    xmem[0] = 4'hA; xmem[1] = 4'h3;
    wmem[0] = w0; wmem[1] = w1; wmem[2] = w2;
    wmem[3] = w3; wmem[4] = w4; wmem[5] = w5;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.err, bus.x_wr_en, bus.class_valid, bus.x_wr_data} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {bus.busy, bus.done, bus.err, bus.x_wr_en, bus.class_valid, bus.x_wr_data});
    end
    n_cmp++;
    if ({bus.w_addr, bus.x_rd_addr, bus.x_wr_addr, bus.class_out} !== 50'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_addrs: got w=%h xr=%h xw=%h c=%h expected all 0",
               bus.w_addr, bus.x_rd_addr, bus.x_wr_addr, bus.class_out);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_match();
    int d, base;
    load_words(4'hA, 4'h3, 4'hA, 4'h3, 4'h0, 4'h0);
    base = wr_cnt;
    run_layer(10'd8, 10'd2, 1'b0, d);
    n_cmp++;
    if (d !== 9) begin n_fail++; $display("[TB] FAIL match_done_cycle: got %0d expected 9", d); end
    n_cmp++;
    if (err_at_done !== 1'b0) begin n_fail++; $display("[TB] FAIL match_err: got %b expected 0", err_at_done); end
    n_cmp++;
    if ({waddr_trace[1], waddr_trace[2], waddr_trace[5], waddr_trace[6]} !== {20'd0, 20'd1, 20'd2, 20'd3}) begin
      n_fail++;
      $display("[TB] FAIL match_w_addr_seq: got %0d,%0d,%0d,%0d expected 0,1,2,3",
               waddr_trace[1], waddr_trace[2], waddr_trace[5], waddr_trace[6]);
    end
    n_cmp++;
    if (wr_cnt - base !== 2) begin n_fail++; $display("[TB] FAIL match_write_count: got %0d expected 2", wr_cnt - base); end
    n_cmp++;
    if ({wr_addr_log[base & 63], wr_data_log[base & 63], wr_addr_log[(base + 1) & 63], wr_data_log[(base + 1) & 63]}
        !== {10'd0, 1'b1, 10'd1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL match_writes: got (%0d,%b) (%0d,%b) expected (0,1) (1,1)",
               wr_addr_log[base & 63], wr_data_log[base & 63],
               wr_addr_log[(base + 1) & 63], wr_data_log[(base + 1) & 63]);
    end
    n_cmp++;
    if ({bus.busy, bus.x_wr_en, bus.x_wr_addr, bus.x_wr_data} !== {1'b0, 1'b0, 10'd1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL match_idle_hold: got busy=%b en=%b addr=%0d data=%b expected 0 0 1 1",
               bus.busy, bus.x_wr_en, bus.x_wr_addr, bus.x_wr_data);
    end
  endtask

  task automatic test_mismatch();
    int d, base;
    load_words(4'h5, 4'hC, 4'h5, 4'hC, 4'h0, 4'h0);
    base = wr_cnt;
    run_layer(10'd8, 10'd2, 1'b0, d);
    n_cmp++;
    if ({d == 9, err_at_done} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL mismatch_done: got cycle=%0d err=%b expected 9 0", d, err_at_done);
    end
    n_cmp++;
    if ({wr_cnt - base == 2, wr_data_log[base & 63], wr_data_log[(base + 1) & 63]} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL mismatch_writes: got count=%0d data=%b,%b expected 2 0,0",
               wr_cnt - base, wr_data_log[base & 63], wr_data_log[(base + 1) & 63]);
    end
  endtask

  // Neuron 0: 4+0 matches (tie, 1). Neuron 1: 1+2 matches (below half, 0).
  task automatic test_tie();
    int d, base;
    load_words(4'hA, 4'hC, 4'hD, 4'h0, 4'h0, 4'h0);
    base = wr_cnt;
    run_layer(10'd8, 10'd2, 1'b0, d);
    n_cmp++;
    if ({wr_cnt - base == 2, wr_data_log[base & 63], wr_data_log[(base + 1) & 63]} !== 3'b110) begin
      n_fail++;
      $display("[TB] FAIL tie_writes: got count=%0d data=%b,%b expected 2 1,0",
               wr_cnt - base, wr_data_log[base & 63], wr_data_log[(base + 1) & 63]);
    end
  endtask

  // acc = 3, 7, 7 -> first of the tied maxima wins, index 1.
  task automatic test_classify();
    int d, base;
    load_words(4'hD, 4'h0, 4'hA, 4'h2, 4'hB, 4'h3);
    base = wr_cnt;
    run_layer(10'd8, 10'd3, 1'b1, d);
    n_cmp++;
    if (d !== 13) begin n_fail++; $display("[TB] FAIL classify_done_cycle: got %0d expected 13", d); end
    n_cmp++;
    if ({cv_at_done, co_at_done, err_at_done} !== {1'b1, 10'd1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL classify_result: got valid=%b class=%0d err=%b expected 1 1 0",
               cv_at_done, co_at_done, err_at_done);
    end
    n_cmp++;
    if (wr_cnt - base !== 0) begin n_fail++; $display("[TB] FAIL classify_no_writes: got %0d expected 0", wr_cnt - base); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.class_valid, bus.class_out} !== {1'b1, 10'd1}) begin
      n_fail++;
      $display("[TB] FAIL classify_hold: got valid=%b class=%0d expected 1 1", bus.class_valid, bus.class_out);
    end
  endtask

  task automatic test_bad_config();
    int d, base;
    base = wr_cnt;
    run_layer(10'd6, 10'd2, 1'b0, d);
    n_cmp++;
    if ({d == 1, err_at_done, cv_at_done} !== 3'b110) begin
      n_fail++;
      $display("[TB] FAIL bad_len_mod: got cycle=%0d err=%b class_valid=%b expected 1 1 0",
               d, err_at_done, cv_at_done);
    end
    n_cmp++;
    if ({bus.busy, wr_cnt - base == 0} !== 2'b01) begin
      n_fail++; $display("[TB] FAIL bad_after: got busy=%b writes=%0d expected 0 0", bus.busy, wr_cnt - base);
    end
    run_layer(10'd0, 10'd2, 1'b0, d);
    n_cmp++;
    if ({d == 1, err_at_done} !== 2'b11) begin
      n_fail++; $display("[TB] FAIL bad_in_zero: got cycle=%0d err=%b expected 1 1", d, err_at_done);
    end
    run_layer(10'd8, 10'd0, 1'b0, d);
    n_cmp++;
    if ({d == 1, err_at_done} !== 2'b11) begin
      n_fail++; $display("[TB] FAIL bad_out_zero: got cycle=%0d err=%b expected 1 1", d, err_at_done);
    end
  endtask

  task automatic test_busy_ignore();
    int d, base;
    load_words(4'hA, 4'h3, 4'hA, 4'h3, 4'h0, 4'h0);
    base = wr_cnt;
    bus.start = 1'b1; bus.in_len = 10'd8; bus.out_len = 10'd2; bus.last = 1'b0;
    d = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      bus.start = (i >= 3 && i < 5);
      if (i == 3) begin bus.in_len = 10'd4; bus.out_len = 10'd1; end
      if (bus.done) begin d = i; break; end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (d !== 9) begin n_fail++; $display("[TB] FAIL busy_ignore_done: got %0d expected 9", d); end
    n_cmp++;
    if ({wr_cnt - base == 2, bus.busy} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL busy_ignore_after: got writes=%0d busy=%b expected 2 0", wr_cnt - base, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int d, base;
    load_words(4'hA, 4'h3, 4'hA, 4'h3, 4'h0, 4'h0);
    base = wr_cnt;
    bus.start = 1'b1; bus.in_len = 10'd8; bus.out_len = 10'd2; bus.last = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.x_wr_en, bus.w_addr, bus.x_rd_addr, bus.x_wr_addr, bus.x_wr_data} !== 44'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_outputs: got busy=%b w=%0d xr=%0d xw=%0d d=%b expected all 0",
               bus.busy, bus.w_addr, bus.x_rd_addr, bus.x_wr_addr, bus.x_wr_data);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_cnt - base !== 1) begin n_fail++; $display("[TB] FAIL reset_mid_writes: got %0d expected 1", wr_cnt - base); end
    base = wr_cnt;
    run_layer(10'd8, 10'd2, 1'b0, d);
    n_cmp++;
    if ({d == 9, wr_cnt - base == 2, wr_data_log[base & 63], wr_data_log[(base + 1) & 63]} !== 4'b1111) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_rerun: got cycle=%0d writes=%0d expected 9 2 with data 1,1", d, wr_cnt - base);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.in_len = '0; bus.out_len = '0; bus.last = 1'b0;
    for (int i = 0; i < 16; i++) begin wmem[i] = 4'h0; xmem[i] = 4'h0; end
    test_reset();
    test_match();
    test_mismatch();
    test_tie();
    test_classify();
    test_bad_config();
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
